// File: rtl/prog_counter.sv
// Programmable up/down counter with a run-time upper bound, wrap or saturate boundary
// handling, one-cycle boundary pulses and a sticky boundary flag.
module prog_counter #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             saturate,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_value,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] counter_out,
    output logic             wrap,
    output logic             sat_hit,
    output logic             bound_sticky
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             sat_next;
    logic             sticky_next;

    always_comb begin
        count_next = counter_out;
        wrap_next  = 1'b0;
        sat_next   = 1'b0;

        if (load) begin
            count_next = (load_value > max_value) ? max_value : load_value;
        end else if (enable) begin
            if (up_down) begin
                // Increment only below the bound, so the WIDTH-bit add never carries out.
                if (counter_out < max_value) begin
                    count_next = counter_out + ONE;
                end else if (saturate) begin
                    count_next = max_value;
                    sat_next   = 1'b1;
                end else begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (counter_out == '0) begin
                    if (saturate) begin
                        sat_next   = 1'b1;
                    end else begin
                        count_next = max_value;
                        wrap_next  = 1'b1;
                    end
                end else if (counter_out > max_value) begin
                    // Bound was lowered under the current count: snap silently.
                    count_next = max_value;
                end else begin
                    count_next = counter_out - ONE;
                end
            end
        end

        sticky_next = wrap_next | sat_next | (bound_sticky & ~clear_flags);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter_out  <= RESET_VAL;
            wrap         <= 1'b0;
            sat_hit      <= 1'b0;
            bound_sticky <= 1'b0;
        end else begin
            counter_out  <= count_next;
            wrap         <= wrap_next;
            sat_hit      <= sat_next;
            bound_sticky <= sticky_next;
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: directed boundary sequences followed by random
// stimulus, each edge's expected outputs queued and checked by an independent monitor.
module tb_prog_counter;

    localparam int unsigned WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             up_down = 1'b0;
    logic             saturate = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic [WIDTH-1:0] max_value = '0;
    logic             clear_flags = 1'b0;
    logic [WIDTH-1:0] counter_out;
    logic             wrap;
    logic             sat_hit;
    logic             bound_sticky;

    typedef struct {
        int unsigned count;
        bit          wrap;
        bit          sat;
        bit          sticky;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference state kept as plain integers.
    int unsigned m_count  = 0;
    bit          m_sticky = 1'b0;

    prog_counter #(.WIDTH(WIDTH), .RESET_VAL(8'd0)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .up_down(up_down),
        .saturate(saturate),
        .load(load),
        .load_value(load_value),
        .max_value(max_value),
        .clear_flags(clear_flags),
        .counter_out(counter_out),
        .wrap(wrap),
        .sat_hit(sat_hit),
        .bound_sticky(bound_sticky)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every edge presents a new registered result one step after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("counter_out", counter_out, e.count);
                check("wrap", wrap, e.wrap);
                check("sat_hit", sat_hit, e.sat);
                check("bound_sticky", bound_sticky, e.sticky);
                checks++;
                if (wrap && sat_hit) begin
                    errors++;
                    $display("FAIL pulse_exclusive: wrap=%0d sat_hit=%0d required not both", wrap, sat_hit);
                end
            end
        end
    end

    task automatic step(input bit r, input bit e, input bit ud, input bit s,
                        input bit l, input int unsigned lv, input int unsigned mx,
                        input bit clr);
        exp_t x;
        @(negedge clock);
        reset = r; enable = e; up_down = ud; saturate = s;
        load = l; load_value = WIDTH'(lv); max_value = WIDTH'(mx); clear_flags = clr;
        x.wrap = 1'b0;
        x.sat  = 1'b0;
        if (r) begin
            m_count  = 0;
            m_sticky = 1'b0;
        end else begin
            if (l) begin
                m_count = (lv < mx) ? lv : mx;
            end else if (e && ud) begin
                if (m_count < mx)  m_count = m_count + 1;
                else if (s)        begin m_count = mx; x.sat = 1'b1; end
                else               begin m_count = 0;  x.wrap = 1'b1; end
            end else if (e) begin
                if (m_count == 0) begin
                    if (s) x.sat = 1'b1;
                    else   begin m_count = mx; x.wrap = 1'b1; end
                end else if (m_count > mx) begin
                    m_count = mx;
                end else begin
                    m_count = m_count - 1;
                end
            end
            if (x.wrap || x.sat) m_sticky = 1'b1;
            else if (clr)        m_sticky = 1'b0;
        end
        x.count  = m_count;
        x.sticky = m_sticky;
        sb.push_back(x);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with load/enable/clear asserted still yields the reset value.
        step(1, 1, 1, 0, 1, 77, 9, 1);
        // Wrap up to max 9 over ten edges.
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0, 9, 0);
        // Saturate at the natural top of range.
        step(0, 0, 1, 1, 1, 253, 255, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0, 255, 0);
        // Down-wrap from zero.
        step(0, 0, 0, 0, 1, 0, 15, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 0, 15, 0);
        // Load clamped, then load beats enable.
        step(0, 0, 1, 0, 1, 200, 100, 0);
        step(0, 1, 1, 0, 1, 7, 100, 0);
        // Bound lowered under the count.
        step(0, 0, 1, 0, 1, 5, 20, 0);
        step(0, 1, 0, 0, 0, 0, 3, 0);
        step(0, 1, 1, 0, 0, 0, 3, 0);
        step(0, 0, 1, 0, 1, 5, 20, 0);
        step(0, 1, 1, 1, 0, 0, 3, 0);
        step(0, 1, 1, 1, 0, 0, 3, 0);
        // Zero bound: every enabled edge pulses.
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // Clear with a simultaneous wrap keeps the flag, clear alone drops it.
        step(0, 0, 1, 0, 1, 4, 4, 0);
        step(0, 1, 1, 0, 0, 0, 4, 1);
        step(0, 0, 1, 0, 0, 0, 4, 1);
        // Mid-count reset with load pending.
        step(0, 1, 1, 0, 0, 0, 4, 0);
        step(1, 1, 1, 0, 1, 3, 4, 0);
        step(0, 1, 1, 0, 0, 0, 4, 0);

        begin
            int unsigned mx = 12;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       mx = 0;
                        1:       mx = 255;
                        2:       mx = $urandom_range(1, 6);
                        default: mx = $urandom_range(0, 255);
                    endcase
                end
                step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 11) == 0, $urandom_range(0, 255), mx,
                     $urandom_range(0, 5) == 0);
            end
        end

        @(negedge clock);
        @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
